led_result_ctrl: RTL and testbench

Parametrised LED front-panel controller for the voting machine, generalising the fixed four-candidate LED driver to NUM_CAND candidates and configurable vote and LED widths. In voting mode it flashes all LEDs for a programmable acknowledge window after each valid vote, with retrigger. In result mode it displays a selected candidate's tally, selected either manually by button or by timed auto-scroll. It also continuously reports the leading candidate and a tie flag. It sits between the vote-counter bank and the board LEDs.

---
 rtl/led_result_ctrl.sv | 156 +++++++++++++++
 tb/tb_led_result_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_result_ctrl.sv
// ============================================================================
// Module   : led_result_ctrl
// Brief    : Voting-machine LED front panel: vote-acknowledge flash, tally
//            display (manual or auto-scroll), live leader and tie reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_result_ctrl #(
  parameter int NUM_CAND      = 4,
  parameter int VOTE_W        = 8,
  parameter int LED_W         = 8,
  parameter int ACK_CYCLES    = 10,
  parameter int SCROLL_CYCLES = 50,
  parameter int IDX_W         = $clog2(NUM_CAND)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       valid_vote_casted,
  input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
  input  logic [NUM_CAND-1:0]        cand_button,
  input  logic                       auto_scroll,
  output logic [LED_W-1:0]           leds,
  output logic [IDX_W-1:0]           shown_idx,
  output logic [IDX_W-1:0]           leader_idx,
  output logic                       tie
);

  localparam int c_ACK_W   = $clog2(ACK_CYCLES + 1);
  localparam int c_DWELL_W = $clog2(SCROLL_CYCLES + 1);
  localparam logic [c_ACK_W-1:0]   c_ACK_LOAD = c_ACK_W'(ACK_CYCLES - 1);
  localparam logic [c_DWELL_W-1:0] c_DWELL_END = c_DWELL_W'(SCROLL_CYCLES - 1);
  localparam logic [IDX_W-1:0]     c_LAST_IDX = IDX_W'(NUM_CAND - 1);

  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_ACK  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_ACK_W-1:0]     r_ack_cnt, w_ack_nxt;
  logic [c_DWELL_W-1:0]   r_dwell_cnt, w_dwell_nxt;
  logic [IDX_W-1:0]       w_shown_nxt;
  logic [LED_W-1:0]       w_leds_nxt;
  logic [VOTE_W-1:0]      w_sel_tally;
  logic [LED_W-1:0]       w_sat;
  logic                   w_btn_any;
  logic [IDX_W-1:0]       w_btn_idx;
  logic [VOTE_W-1:0]      w_max;
  logic [IDX_W-1:0]       w_lead;
  logic                   w_tie;

  always_comb begin
    w_btn_any = |cand_button;
    w_btn_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (cand_button[i]) w_btn_idx = IDX_W'(i);
    end
  end

  // Strict greater-than keeps the lowest index on equal tallies.
  always_comb begin
    w_max  = cand_votes[VOTE_W-1:0];
    w_lead = '0;
    w_tie  = 1'b0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (cand_votes[i*VOTE_W +: VOTE_W] > w_max) begin
        w_max  = cand_votes[i*VOTE_W +: VOTE_W];
        w_lead = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (cand_votes[i*VOTE_W +: VOTE_W] == w_max && IDX_W'(i) != w_lead) w_tie = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack_cnt;
    w_dwell_nxt = r_dwell_cnt;
    w_shown_nxt = shown_idx;
    case (r_state)
      V_IDLE, V_ACK: begin
        if (mode) begin
          w_state_nxt = RESULT;
          w_shown_nxt = '0;
          w_dwell_nxt = '0;
        end else if (valid_vote_casted) begin
          w_state_nxt = V_ACK;
          w_ack_nxt   = c_ACK_LOAD;
        end else if (r_state == V_ACK) begin
          if (r_ack_cnt == '0) w_state_nxt = V_IDLE;
          else                 w_ack_nxt   = r_ack_cnt - 1'b1;
        end
      end
      RESULT: begin
        if (!mode) begin
          w_state_nxt = V_IDLE;
        end else if (w_btn_any) begin
          w_shown_nxt = w_btn_idx;
          w_dwell_nxt = '0;
        end else if (auto_scroll && r_dwell_cnt == c_DWELL_END) begin
          w_shown_nxt = (shown_idx == c_LAST_IDX) ? '0 : shown_idx + 1'b1;
          w_dwell_nxt = '0;
        end else if (auto_scroll) begin
          w_dwell_nxt = r_dwell_cnt + 1'b1;
        end else begin
          w_dwell_nxt = '0;
        end
      end
      default: w_state_nxt = V_IDLE;
    endcase
  end

  // Display follows the index being loaded this edge, so tallies track live.
  assign w_sel_tally = cand_votes[w_shown_nxt*VOTE_W +: VOTE_W];

  generate
    if (VOTE_W > LED_W) begin : g_sat_clip
      assign w_sat = (|w_sel_tally[VOTE_W-1:LED_W]) ? '1 : w_sel_tally[LED_W-1:0];
    end else begin : g_sat_ext
      assign w_sat = LED_W'(w_sel_tally);
    end
  endgenerate

  always_comb begin
    w_leds_nxt = '0;
    if (w_state_nxt == RESULT)     w_leds_nxt = w_sat;
    else if (w_state_nxt == V_ACK) w_leds_nxt = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= V_IDLE;
      r_ack_cnt   <= '0;
      r_dwell_cnt <= '0;
      leds        <= '0;
      shown_idx   <= '0;
      leader_idx  <= '0;
      tie         <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ack_cnt   <= w_ack_nxt;
      r_dwell_cnt <= w_dwell_nxt;
      leds        <= w_leds_nxt;
      shown_idx   <= w_shown_nxt;
      leader_idx  <= w_lead;
      tie         <= w_tie;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_result_ctrl.sv
// ============================================================================
// Module   : tb_led_result_ctrl
// Brief    : Directed, table-driven bench for led_result_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_result_ctrl;

  localparam int NC = 4;
  localparam int VW = 10;
  localparam int LW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic              valid_vote_casted;
  logic [NC*VW-1:0]  cand_votes;
  logic [NC-1:0]     cand_button;
  logic              auto_scroll;
  logic [LW-1:0]     leds;
  logic [1:0]        shown_idx;
  logic [1:0]        leader_idx;
  logic              tie;

  int total = 0;
  int bad   = 0;

  led_result_ctrl #(
    .NUM_CAND(NC), .VOTE_W(VW), .LED_W(LW), .ACK_CYCLES(10), .SCROLL_CYCLES(5)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .valid_vote_casted(valid_vote_casted),
    .cand_votes(cand_votes), .cand_button(cand_button), .auto_scroll(auto_scroll),
    .leds(leds), .shown_idx(shown_idx), .leader_idx(leader_idx), .tie(tie)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        vote;
    logic [39:0] votes;
    logic [3:0]  btn;
    logic [7:0]  e_leds;
    logic [1:0]  e_shown;
    logic [1:0]  e_lead;
    logic        e_tie;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [39:0] pk(int a, int b, int c, int d);
    return {10'(d), 10'(c), 10'(b), 10'(a)};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, pk(3,7,7,1),      4'b0000,   3, 0, 1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, pk(3,7,7,1),      4'b0100,   7, 2, 1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, pk(3,7,7,1),      4'b1010,   7, 1, 1, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, pk(300,200,5,5),  4'b0000, 200, 1, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, pk(300,200,5,5),  4'b0001, 255, 0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, pk(0,0,0,0),      4'b0000,   0, 0, 0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, pk(0,0,0,1023),   4'b1000, 255, 3, 3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, pk(5,9,9,9),      4'b0000,   9, 3, 1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, pk(5,9,9,9),      4'b0000,   0, 3, 1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, pk(5,9,9,9),      4'b0000, 255, 3, 1, 1'b1};
    tbl[10] = '{1'b1, 1'b0, pk(5,9,9,9),      4'b0000,   5, 0, 1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, pk(5,9,9,9),      4'b0000,   5, 0, 1, 1'b1};

    reset = 1'b1; mode = 1'b0; valid_vote_casted = 1'b0;
    cand_votes = '0; cand_button = '0; auto_scroll = 1'b0;
    tick(); tick();
    chk("rst_leds", leds, 0);
    chk("rst_shown", shown_idx, 0);
    chk("rst_leader", leader_idx, 0);
    chk("rst_tie", tie, 0);
    reset = 1'b0;
    tick();

    // Single flash: high for exactly 10 cycles
    valid_vote_casted = 1'b1; tick(); valid_vote_casted = 1'b0;
    chk("flash_1", leds, 8'hFF);
    for (int i = 2; i <= 10; i++) begin
      tick(); chk($sformatf("flash_%0d", i), leds, 8'hFF);
    end
    tick(); chk("flash_end", leds, 0);
    tick(); chk("flash_idle", leds, 0);

    // Retrigger 4 cycles after the first vote: 14 cycles high
    valid_vote_casted = 1'b1; tick(); valid_vote_casted = 1'b0;
    chk("retrig_0", leds, 8'hFF);
    for (int i = 1; i <= 3; i++) begin
      tick(); chk($sformatf("retrig_%0d", i), leds, 8'hFF);
    end
    valid_vote_casted = 1'b1; tick(); valid_vote_casted = 1'b0;
    chk("retrig_4", leds, 8'hFF);
    for (int i = 5; i <= 13; i++) begin
      tick(); chk($sformatf("retrig_%0d", i), leds, 8'hFF);
    end
    tick(); chk("retrig_end", leds, 0);

    for (int i = 0; i < 12; i++) begin
      mode = tbl[i].mode; valid_vote_casted = tbl[i].vote;
      cand_votes = tbl[i].votes; cand_button = tbl[i].btn;
      tick();
      chk($sformatf("vec%0d_leds", i), leds, tbl[i].e_leds);
      chk($sformatf("vec%0d_shown", i), shown_idx, tbl[i].e_shown);
      chk($sformatf("vec%0d_leader", i), leader_idx, tbl[i].e_lead);
      chk($sformatf("vec%0d_tie", i), tie, tbl[i].e_tie);
    end
    valid_vote_casted = 1'b0;

    // Abort a flash three cycles in
    mode = 1'b0; tick(); chk("abort_idle", leds, 0);
    cand_votes = pk(42,1,2,3);
    valid_vote_casted = 1'b1; tick(); valid_vote_casted = 1'b0;
    chk("abort_flash", leds, 8'hFF);
    tick(); tick(); chk("abort_flash2", leds, 8'hFF);
    mode = 1'b1; tick();
    chk("abort_leds", leds, 42);
    chk("abort_shown", shown_idx, 0);

    // Auto-scroll: one step every 5 cycles, wrapping
    cand_votes = pk(10,20,30,40); auto_scroll = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      int es;
      tick();
      es = (k / 5) % 4;
      chk($sformatf("scroll_shown_%0d", k), shown_idx, es);
      chk($sformatf("scroll_leds_%0d", k), leds, 10 * (es + 1));
    end
    tick(); tick();
    cand_button = 4'b0100; tick(); cand_button = '0;
    chk("mid_btn_shown", shown_idx, 2);
    chk("mid_btn_leds", leds, 30);
    for (int k = 1; k <= 5; k++) begin
      tick(); chk($sformatf("restart_%0d", k), shown_idx, (k < 5) ? 2 : 3);
    end

    // Held button freezes scrolling
    cand_button = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      tick(); chk($sformatf("hold_%0d", k), shown_idx, 1);
    end
    cand_button = '0;
    for (int k = 1; k <= 5; k++) begin
      tick(); chk($sformatf("release_%0d", k), shown_idx, (k < 5) ? 1 : 2);
    end

    // Reset mid-scroll
    tick(); tick();
    reset = 1'b1; tick();
    chk("midrst_leds", leds, 0);
    chk("midrst_shown", shown_idx, 0);
    chk("midrst_leader", leader_idx, 0);
    chk("midrst_tie", tie, 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
